sram_like_arbiter: RTL and testbench

SRAM_LIKE_ARBITER -- requirements
Module: sram_like_arbiter

---
 rtl/sram_like_arbiter.sv | 122 ++++++++++++
 tb/tb_sram_like_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter
//   Shares one SRAM-like slave port between an instruction master and a data
//   master. At most one slave transaction is in flight. A three-state FSM
//   (IDLE -> ADDR -> DATA) runs alongside a registered owner bit.
//   Tie-break when both masters request in the same cycle:
//     DATA_FIRST = 1 : the data port always wins.
//     DATA_FIRST = 0 : round-robin. The port not granted last wins, and the
//                      first tie after reset goes to data.
//
// Ports
//   clk, rst                      : single clock, synchronous active-high reset
//   inst_req/wr/size/addr/wdata   : instruction master request channel
//   inst_addr_ok/data_ok/rdata    : instruction master responses
//   data_req/wr/size/addr/wdata   : data master request channel
//   data_addr_ok/data_ok/rdata    : data master responses
//   mem_req/wr/size/addr/wdata    : request channel to the shared slave
//   mem_addr_ok/data_ok/rdata     : responses from the shared slave
module sram_like_arbiter #(
  parameter bit DATA_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

  state_t r_state;
  logic   r_owner;    // 0 = inst, 1 = data
  logic   r_rr_data;  // round-robin: 1 = data wins the next tie

  logic w_in_addr;
  logic w_owner_req;
  logic w_mem_req;
  logic w_addr_hs;
  logic w_data_hs;
  logic w_grant_data;

  assign w_in_addr   = (r_state == S_ADDR);
  assign w_owner_req = r_owner ? data_req : inst_req;
  // If the owner withdraws its request before it is accepted, the slave must
  // not see a request that nobody will follow up on.
  assign w_mem_req   = w_in_addr && w_owner_req;
  assign w_addr_hs   = w_mem_req && mem_addr_ok;
  // Data completes in DATA, or in ADDR when the slave answers in the same
  // cycle as it accepts the address. mem_data_ok in IDLE is ignored.
  assign w_data_hs   = ((r_state == S_DATA) && mem_data_ok) ||
                       (w_addr_hs && mem_data_ok);

  // Grant decision used only in IDLE.
  assign w_grant_data = data_req && (!inst_req || DATA_FIRST || r_rr_data);

  // Slave request channel follows the owner while in ADDR, zero otherwise.
  assign mem_req   = w_mem_req;
  assign mem_wr    = w_in_addr ? (r_owner ? data_wr    : inst_wr)    : 1'b0;
  assign mem_size  = w_in_addr ? (r_owner ? data_size  : inst_size)  : 2'b00;
  assign mem_addr  = w_in_addr ? (r_owner ? data_addr  : inst_addr)  : 32'h0;
  assign mem_wdata = w_in_addr ? (r_owner ? data_wdata : inst_wdata) : 32'h0;

  // Acknowledges go only to the owner; the other port always sees zeros.
  assign inst_addr_ok = w_addr_hs && !r_owner;
  assign data_addr_ok = w_addr_hs &&  r_owner;
  assign inst_data_ok = w_data_hs && !r_owner;
  assign data_data_ok = w_data_hs &&  r_owner;
  assign inst_rdata   = inst_data_ok ? mem_rdata : 32'h0;
  assign data_rdata   = data_data_ok ? mem_rdata : 32'h0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_owner   <= 1'b1;
      r_rr_data <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (inst_req || data_req) begin
            r_owner   <= w_grant_data;
            r_rr_data <= !w_grant_data;
            r_state   <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (!w_owner_req) begin
            r_state <= S_IDLE;
          end else if (w_addr_hs) begin
            r_state <= mem_data_ok ? S_IDLE : S_DATA;
          end
        end
        S_DATA: begin
          if (mem_data_ok) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed testbench for sram_like_arbiter. Two instances share every input:
// dut (DATA_FIRST=1) and dut_rr (DATA_FIRST=0, outputs prefixed rr_).
module tb_sram_like_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        inst_req = 1'b0, inst_wr = 1'b0;
  logic [1:0]  inst_size = 2'd0;
  logic [31:0] inst_addr = 32'h0, inst_wdata = 32'h0;
  logic        data_req = 1'b0, data_wr = 1'b0;
  logic [1:0]  data_size = 2'd0;
  logic [31:0] data_addr = 32'h0, data_wdata = 32'h0;
  logic        mem_addr_ok = 1'b0, mem_data_ok = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata;

  logic        rr_inst_addr_ok, rr_inst_data_ok, rr_data_addr_ok, rr_data_data_ok;
  logic [31:0] rr_inst_rdata, rr_data_rdata;
  logic        rr_mem_req, rr_mem_wr;
  logic [1:0]  rr_mem_size;
  logic [31:0] rr_mem_addr, rr_mem_wdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sram_like_arbiter #(.DATA_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  sram_like_arbiter #(.DATA_FIRST(1'b0)) dut_rr (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(rr_inst_addr_ok), .inst_data_ok(rr_inst_data_ok), .inst_rdata(rr_inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(rr_data_addr_ok), .data_data_ok(rr_data_data_ok), .data_rdata(rr_data_rdata),
    .mem_req(rr_mem_req), .mem_wr(rr_mem_wr), .mem_size(rr_mem_size),
    .mem_addr(rr_mem_addr), .mem_wdata(rr_mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  // Advance one clock; inputs are changed and outputs sampled 1 time unit
  // after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    inst_req = 1'b0; inst_wr = 1'b0; inst_size = 2'd0; inst_addr = 32'h0; inst_wdata = 32'h0;
    data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0; data_addr = 32'h0; data_wdata = 32'h0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'h0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    // Slave noise while IDLE must not leak to either master.
    mem_addr_ok = 1'b1; mem_data_ok = 1'b1; mem_rdata = 32'h12345678;
    #1;
    n_checks++;
    if ({mem_req, mem_wr, mem_size, mem_addr, mem_wdata, inst_addr_ok, inst_data_ok,
         inst_rdata, data_addr_ok, data_data_ok, data_rdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs_df: got mem_req=%0b iack=%0b/%0b dack=%0b/%0b, want all 0",
               mem_req, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok);
    end
    n_checks++;
    if ({rr_mem_req, rr_mem_wr, rr_mem_size, rr_mem_addr, rr_mem_wdata, rr_inst_addr_ok,
         rr_inst_data_ok, rr_inst_rdata, rr_data_addr_ok, rr_data_data_ok, rr_data_rdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs_rr: got mem_req=%0b iack=%0b/%0b dack=%0b/%0b, want all 0",
               rr_mem_req, rr_inst_addr_ok, rr_inst_data_ok, rr_data_addr_ok, rr_data_data_ok);
    end
    tick();
    n_checks++;
    if (mem_req !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle_stays: mem_req got %0b want 0", mem_req);
    end
    clear_inputs();
    $display("txn reset: outputs zero after reset");
  endtask

  task automatic test_inst_read();
    do_reset();
    inst_req = 1'b1; inst_addr = 32'hBFC00000; inst_size = 2'd2;
    #1;
    n_checks++;
    if (mem_req !== 1'b0) begin
      n_fail++; $display("FAIL inst_read_c0_mem_req: got %0b want 0", mem_req);
    end
    tick(); // cycle 1: ADDR
    mem_addr_ok = 1'b1;
    #1;
    n_checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'hBFC00000 || mem_wr !== 1'b0 || mem_size !== 2'd2) begin
      n_fail++; $display("FAIL inst_read_c1_mem: got req=%0b addr=%h wr=%0b size=%0d want 1/bfc00000/0/2",
                         mem_req, mem_addr, mem_wr, mem_size);
    end
    n_checks++;
    if (inst_addr_ok !== 1'b1 || data_addr_ok !== 1'b0) begin
      n_fail++; $display("FAIL inst_read_c1_addr_ok: got inst=%0b data=%0b want 1/0", inst_addr_ok, data_addr_ok);
    end
    tick(); // cycle 2: DATA
    inst_req = 1'b0; mem_addr_ok = 1'b0;
    #1;
    n_checks++;
    if (mem_req !== 1'b0 || inst_data_ok !== 1'b0) begin
      n_fail++; $display("FAIL inst_read_c2_wait: got mem_req=%0b data_ok=%0b want 0/0", mem_req, inst_data_ok);
    end
    tick(); // cycle 3: response
    mem_data_ok = 1'b1; mem_rdata = 32'h3C1D0001;
    #1;
    n_checks++;
    if (inst_data_ok !== 1'b1 || inst_rdata !== 32'h3C1D0001) begin
      n_fail++; $display("FAIL inst_read_c3_data: got ok=%0b rdata=%h want 1/3c1d0001", inst_data_ok, inst_rdata);
    end
    n_checks++;
    if (data_data_ok !== 1'b0 || data_rdata !== 32'h0) begin
      n_fail++; $display("FAIL inst_read_c3_other: got data_data_ok=%0b rdata=%h want 0/0", data_data_ok, data_rdata);
    end
    tick();
    mem_data_ok = 1'b0;
    #1;
    n_checks++;
    if (mem_req !== 1'b0 || inst_data_ok !== 1'b0 || inst_rdata !== 32'h0) begin
      n_fail++; $display("FAIL inst_read_c4_idle: got req=%0b ok=%0b rdata=%h want 0/0/0", mem_req, inst_data_ok, inst_rdata);
    end
    clear_inputs();
    $display("txn inst_read: addr bfc00000 rdata %h", 32'h3C1D0001);
  endtask

  task automatic test_data_first();
    do_reset();
    inst_req = 1'b1; inst_addr = 32'h00000100;
    data_req = 1'b1; data_addr = 32'h00000200;
    tick(); // ADDR
    mem_addr_ok = 1'b1;
    #1;
    n_checks++;
    if (mem_addr !== 32'h00000200 || data_addr_ok !== 1'b1 || inst_addr_ok !== 1'b0) begin
      n_fail++; $display("FAIL data_first_grant: got addr=%h dack=%0b iack=%0b want 00000200/1/0",
                         mem_addr, data_addr_ok, inst_addr_ok);
    end
    tick(); // DATA
    data_req = 1'b0; mem_addr_ok = 1'b0;
    tick();
    mem_data_ok = 1'b1; mem_rdata = 32'hA5A5A5A5;
    #1;
    n_checks++;
    if (data_data_ok !== 1'b1 || data_rdata !== 32'hA5A5A5A5 || inst_data_ok !== 1'b0) begin
      n_fail++; $display("FAIL data_first_data_ok: got dok=%0b rdata=%h iok=%0b want 1/a5a5a5a5/0",
                         data_data_ok, data_rdata, inst_data_ok);
    end
    tick(); // IDLE, inst still requesting
    mem_data_ok = 1'b0;
    #1;
    n_checks++;
    if (mem_req !== 1'b0) begin
      n_fail++; $display("FAIL data_first_gap: mem_req got %0b want 0", mem_req);
    end
    tick(); // ADDR for inst; slave accepts and answers in the same cycle
    mem_addr_ok = 1'b1; mem_data_ok = 1'b1; mem_rdata = 32'h0BADF00D;
    #1;
    n_checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h00000100) begin
      n_fail++; $display("FAIL data_first_inst_grant: got req=%0b addr=%h want 1/00000100", mem_req, mem_addr);
    end
    n_checks++;
    if (inst_addr_ok !== 1'b1 || inst_data_ok !== 1'b1 || inst_rdata !== 32'h0BADF00D) begin
      n_fail++; $display("FAIL coincide_acks: got aok=%0b dok=%0b rdata=%h want 1/1/0badf00d",
                         inst_addr_ok, inst_data_ok, inst_rdata);
    end
    tick();
    inst_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
    #1;
    n_checks++;
    if (mem_req !== 1'b0 || inst_data_ok !== 1'b0) begin
      n_fail++; $display("FAIL coincide_idle_next: got req=%0b dok=%0b want 0/0", mem_req, inst_data_ok);
    end
    tick();
    n_checks++;
    if (mem_req !== 1'b0) begin
      n_fail++; $display("FAIL coincide_no_extra: mem_req got %0b want 0", mem_req);
    end
    clear_inputs();
    $display("txn data_first: data served, then inst");
  endtask

  task automatic test_round_robin();
    logic exp_data;
    do_reset();
    inst_req = 1'b1; inst_addr = 32'h11110000;
    data_req = 1'b1; data_addr = 32'h22220000;
    exp_data = 1'b1;
    for (int t = 0; t < 4; t++) begin
      #1;
      n_checks++;
      if (rr_mem_req !== 1'b0) begin
        n_fail++; $display("FAIL rr_idle_%0d: mem_req got %0b want 0", t, rr_mem_req);
      end
      tick(); // ADDR
      mem_addr_ok = 1'b1; mem_data_ok = 1'b1;
      #1;
      n_checks++;
      if (rr_data_addr_ok !== exp_data || rr_inst_addr_ok !== !exp_data ||
          rr_mem_addr !== (exp_data ? 32'h22220000 : 32'h11110000)) begin
        n_fail++; $display("FAIL rr_grant_%0d: got dack=%0b iack=%0b addr=%h want data=%0b",
                           t, rr_data_addr_ok, rr_inst_addr_ok, rr_mem_addr, exp_data);
      end
      n_checks++;
      if (data_addr_ok !== 1'b1 || inst_addr_ok !== 1'b0) begin
        n_fail++; $display("FAIL df_fixed_grant_%0d: got dack=%0b iack=%0b want 1/0", t, data_addr_ok, inst_addr_ok);
      end
      $display("txn rr %0d: granted %s", t, rr_data_addr_ok ? "data" : "inst");
      tick();
      mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
      exp_data = !exp_data;
    end
    clear_inputs();
  endtask

  task automatic test_write();
    int pulses;
    do_reset();
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2;
    data_addr = 32'h80001000; data_wdata = 32'hDEADBEEF;
    tick(); // ADDR
    mem_addr_ok = 1'b1;
    #1;
    n_checks++;
    if (mem_req !== 1'b1 || mem_wr !== 1'b1 || mem_size !== 2'd2 ||
        mem_addr !== 32'h80001000 || mem_wdata !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL write_mem_fields: got req=%0b wr=%0b size=%0d addr=%h wdata=%h want 1/1/2/80001000/deadbeef",
                         mem_req, mem_wr, mem_size, mem_addr, mem_wdata);
    end
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      data_req = 1'b0; mem_addr_ok = 1'b0;
      // Response in cycle 1; a stray response in IDLE (cycle 3) must be ignored.
      mem_data_ok = (c == 1) || (c == 3);
      #1;
      if (data_data_ok === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses != 1) begin
      n_fail++; $display("FAIL write_data_ok_pulses: got %0d want 1", pulses);
    end
    clear_inputs();
    $display("txn write: addr 80001000 wdata deadbeef");
  endtask

  task automatic test_reset_mid();
    do_reset();
    inst_req = 1'b1; inst_addr = 32'h00004000;
    tick(); // ADDR
    mem_addr_ok = 1'b1;
    tick(); // DATA
    inst_req = 1'b0; mem_addr_ok = 1'b0;
    rst = 1'b1;
    tick(); // reset taken
    rst = 1'b0;
    mem_data_ok = 1'b1; mem_rdata = 32'hCAFEF00D;
    #1;
    n_checks++;
    if (inst_data_ok !== 1'b0 || data_data_ok !== 1'b0 || inst_rdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_mid_no_data_ok: got iok=%0b dok=%0b rdata=%h want 0/0/0",
                         inst_data_ok, data_data_ok, inst_rdata);
    end
    n_checks++;
    if (mem_req !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_mem_req: got %0b want 0", mem_req);
    end
    tick();
    mem_data_ok = 1'b0;
    #1;
    n_checks++;
    if (mem_req !== 1'b0 || inst_data_ok !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_idle: got req=%0b iok=%0b want 0/0", mem_req, inst_data_ok);
    end
    clear_inputs();
    $display("txn reset_mid: in-flight response discarded");
  endtask

  task automatic test_drop();
    do_reset();
    inst_req = 1'b1; inst_addr = 32'h00008000;
    tick(); // ADDR, slave not ready, master withdraws
    inst_req = 1'b0;
    #1;
    n_checks++;
    if (inst_addr_ok !== 1'b0) begin
      n_fail++; $display("FAIL drop_no_ack: inst_addr_ok got %0b want 0", inst_addr_ok);
    end
    tick(); // back in IDLE; slave asserting accept must not ack anyone
    mem_addr_ok = 1'b1; mem_data_ok = 1'b1;
    #1;
    n_checks++;
    if (mem_req !== 1'b0 || inst_addr_ok !== 1'b0 || inst_data_ok !== 1'b0) begin
      n_fail++; $display("FAIL drop_idle: got req=%0b aok=%0b dok=%0b want 0/0/0", mem_req, inst_addr_ok, inst_data_ok);
    end
    clear_inputs();
    $display("txn drop: request withdrawn in ADDR");
  endtask

  initial begin
    test_reset();
    test_inst_read();
    test_data_first();
    test_round_robin();
    test_write();
    test_reset_mid();
    test_drop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
